// File: rtl/reg_32_shift_ctrl.sv
// reg_32_shift_ctrl
//   Sequencer for a structural shift register. A command (word, direction,
//   length, fill bit) is accepted over CMD_VALID/CMD_READY, parallel-loaded
//   into the register for one cycle, and then shifted for the programmed
//   number of cycles. The bits coming back on SER_RET are collected into
//   RX_WORD, and DONE pulses for one cycle at the end of the command.
//
// Ports
//   CLK, RESET_L         clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY  command handshake (READY only while idle)
//   CMD_WORD/DIR/LEN/FILL command fields (LEN 0 or > WIDTH means WIDTH)
//   SER_RET              serial bit returned by the register
//   ENB, MODO, DIR, D, S_IN  register control outputs
//   BUSY, DONE, RX_WORD  status and the collected word
//   All outputs are registered.
module reg_32_shift_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_WORD,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_LEN,
  input  logic             CMD_FILL,
  input  logic             SER_RET,
  output logic             ENB,
  output logic [1:0]       MODO,
  output logic             DIR,
  output logic [WIDTH-1:0] D,
  output logic             S_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RX_WORD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_fill;

  logic             w_accept;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_cnt;
  logic             w_ready;
  logic             w_enb;
  logic [1:0]       w_modo;
  logic             w_dir;
  logic [WIDTH-1:0] w_d;
  logic             w_s_in;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_rx;

  assign w_accept = CMD_VALID && CMD_READY;

  // Zero and anything above WIDTH both mean a full-width shift.
  always_comb begin
    w_len = CMD_LEN;
    if (CMD_LEN == '0 || CMD_LEN > CNT_W'(WIDTH))
      w_len = CNT_W'(WIDTH);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so their next values follow the next state.
  // The word goes straight into D on acceptance; D holds it afterwards,
  // which doubles as the latched copy of the command word.
  always_comb begin
    w_ready = 1'b0;
    w_enb   = 1'b0;
    w_modo  = 2'b11;
    w_dir   = DIR;
    w_d     = D;
    w_s_in  = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (w_state_nxt)
      IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
      LOAD: begin
        w_enb  = 1'b1;
        w_modo = 2'b10;
        w_dir  = CMD_DIR;
        w_d    = CMD_WORD;
      end
      SHIFT: begin
        w_enb  = 1'b1;
        w_modo = 2'b00;
        w_dir  = r_dir;
        w_s_in = r_fill;
      end
      FIN: begin
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_cnt = r_cnt;
    w_rx  = RX_WORD;
    if (w_accept) begin
      w_cnt = w_len;
      w_rx  = '0;
    end else if (r_state == SHIFT) begin
      w_cnt = r_cnt - CNT_W'(1);
      if (r_dir)
        w_rx = {RX_WORD[WIDTH-2:0], SER_RET};
      else
        w_rx = {SER_RET, RX_WORD[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_fill    <= 1'b0;
      CMD_READY <= 1'b1;
      ENB       <= 1'b0;
      MODO      <= 2'b11;
      DIR       <= 1'b0;
      D         <= '0;
      S_IN      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RX_WORD   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt;
      if (w_accept) begin
        r_dir  <= CMD_DIR;
        r_fill <= CMD_FILL;
      end
      CMD_READY <= w_ready;
      ENB       <= w_enb;
      MODO      <= w_modo;
      DIR       <= w_dir;
      D         <= w_d;
      S_IN      <= w_s_in;
      BUSY      <= w_busy;
      DONE      <= w_done;
      RX_WORD   <= w_rx;
    end
  end

endmodule

// File: tb/tb_reg_32_shift_ctrl.sv
// Directed testbench for reg_32_shift_ctrl with a behavioural model of the
// attached 32-bit shift register feeding SER_RET.
module tb_reg_32_shift_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [31:0] CMD_WORD;
  logic        CMD_DIR;
  logic [5:0]  CMD_LEN;
  logic        CMD_FILL;
  logic        SER_RET;
  logic        ENB;
  logic [1:0]  MODO;
  logic        DIR;
  logic [31:0] D;
  logic        S_IN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RX_WORD;

  int checks   = 0;
  int failures = 0;

  logic        use_model;
  logic        ser_force;
  logic [31:0] mdl;

  // observations from run_cmd
  int          n_shift;
  int          done_at;
  logic [31:0] obs_rx, obs_d, obs_rx_load;
  logic [1:0]  obs_modo;
  logic        obs_enb, shift_ok, post_ok;

  always #5 CLK = ~CLK;

  reg_32_shift_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WORD(CMD_WORD), .CMD_DIR(CMD_DIR), .CMD_LEN(CMD_LEN), .CMD_FILL(CMD_FILL),
    .SER_RET(SER_RET), .ENB(ENB), .MODO(MODO), .DIR(DIR), .D(D), .S_IN(S_IN),
    .BUSY(BUSY), .DONE(DONE), .RX_WORD(RX_WORD)
  );

  // Register model: load on MODO=10, shift on MODO=00, S_OUT from the end
  // the data moves toward.
  always @(posedge CLK) begin
    if (ENB && MODO == 2'b10) mdl <= D;
    else if (ENB && MODO == 2'b00) mdl <= DIR ? {mdl[30:0], S_IN} : {S_IN, mdl[31:1]};
  end
  assign SER_RET = use_model ? (DIR ? mdl[31] : mdl[0]) : ser_force;

  // Issues one command starting at a negedge in IDLE; returns at a negedge
  // one cycle after DONE (or after the cycle budget runs out).
  task automatic run_cmd(input logic [31:0] w, input logic dir, input logic [5:0] len, input logic fill);
    n_shift = 0; done_at = -1; shift_ok = 1'b1; obs_rx = 'x;
    CMD_VALID = 1'b1; CMD_WORD = w; CMD_DIR = dir; CMD_LEN = len; CMD_FILL = fill;
    @(negedge CLK);
    obs_d = D; obs_modo = MODO; obs_enb = ENB; obs_rx_load = RX_WORD;
    CMD_VALID = 1'b0;
    for (int i = 2; i < 80; i++) begin
      @(negedge CLK);
      if (ENB && MODO == 2'b00) begin
        n_shift++;
        if (DIR !== dir || S_IN !== fill) shift_ok = 1'b0;
      end
      if (DONE === 1'b1) begin
        done_at = i; obs_rx = RX_WORD;
        post_ok = BUSY && !ENB && MODO == 2'b11;
        break;
      end
    end
    @(negedge CLK);
    post_ok = post_ok && CMD_READY && !BUSY && !DONE && !ENB && MODO == 2'b11;
  endtask

  task automatic test_reset();
    RESET_L = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      CMD_VALID = 1'($urandom); CMD_WORD = $urandom; CMD_DIR = 1'($urandom);
      CMD_LEN = 6'($urandom); CMD_FILL = 1'($urandom); ser_force = 1'($urandom);
    end
    @(negedge CLK);
    checks++; if (CMD_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", CMD_READY); end
    checks++; if (ENB !== 1'b0) begin failures++; $display("FAIL reset_enb got=%b want=0", ENB); end
    checks++; if (MODO !== 2'b11) begin failures++; $display("FAIL reset_modo got=%b want=11", MODO); end
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL reset_done_busy got=%b%b want=00", DONE, BUSY); end
    checks++; if (RX_WORD !== 32'h0) begin failures++; $display("FAIL reset_rx got=%h want=0", RX_WORD); end
    checks++; if (D !== 32'h0 || S_IN !== 1'b0 || DIR !== 1'b0) begin failures++; $display("FAIL reset_d_sin_dir got=%h %b %b want=0 0 0", D, S_IN, DIR); end
    CMD_VALID = 1'b0;
    RESET_L = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_shift();
    use_model = 1'b0; ser_force = 1'b1;
    run_cmd(32'hA5A5_0001, 1'b1, 6'd1, 1'b0);
    checks++; if (obs_enb !== 1'b1 || obs_modo !== 2'b10) begin failures++; $display("FAIL single_load_mode got=%b %b want=1 10", obs_enb, obs_modo); end
    checks++; if (obs_d !== 32'hA5A5_0001) begin failures++; $display("FAIL single_load_d got=%h want=a5a50001", obs_d); end
    checks++; if (n_shift !== 1 || shift_ok !== 1'b1) begin failures++; $display("FAIL single_shift_cycles got=%0d ok=%b want=1 ok=1", n_shift, shift_ok); end
    checks++; if (done_at !== 3) begin failures++; $display("FAIL single_done_at got=%0d want=3", done_at); end
    checks++; if (obs_rx !== 32'h0000_0001) begin failures++; $display("FAIL single_rx got=%h want=00000001", obs_rx); end
    checks++; if (post_ok !== 1'b1) begin failures++; $display("FAIL single_fin_idle got=%b want=1", post_ok); end
  endtask

  task automatic test_loopback();
    use_model = 1'b1;
    run_cmd(32'h1234_5678, 1'b0, 6'd0, 1'b1);
    checks++; if (obs_rx_load !== 32'h0) begin failures++; $display("FAIL loop_rx_cleared got=%h want=0", obs_rx_load); end
    checks++; if (n_shift !== 32 || shift_ok !== 1'b1) begin failures++; $display("FAIL loop_shift_cycles got=%0d ok=%b want=32 ok=1", n_shift, shift_ok); end
    checks++; if (done_at !== 34) begin failures++; $display("FAIL loop_done_at got=%0d want=34", done_at); end
    checks++; if (obs_rx !== 32'h1234_5678) begin failures++; $display("FAIL loop_rx got=%h want=12345678", obs_rx); end
    checks++; if (mdl !== 32'hFFFF_FFFF) begin failures++; $display("FAIL loop_fill got=%h want=ffffffff", mdl); end
    run_cmd(32'h9A00_0000, 1'b1, 6'd8, 1'b1);
    checks++; if (n_shift !== 8 || done_at !== 10) begin failures++; $display("FAIL msb8_timing got=%0d/%0d want=8/10", n_shift, done_at); end
    checks++; if (obs_rx !== 32'h0000_009A) begin failures++; $display("FAIL msb8_rx got=%h want=0000009a", obs_rx); end
    checks++; if (mdl !== 32'h0000_00FF) begin failures++; $display("FAIL msb8_fill got=%h want=000000ff", mdl); end
  endtask

  task automatic test_saturation();
    use_model = 1'b1;
    run_cmd(32'hDEAD_BEEF, 1'b1, 6'd40, 1'b0);
    checks++; if (n_shift !== 32) begin failures++; $display("FAIL sat_shift_cycles got=%0d want=32", n_shift); end
    checks++; if (done_at !== 34) begin failures++; $display("FAIL sat_done_at got=%0d want=34", done_at); end
    checks++; if (obs_rx !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sat_rx got=%h want=deadbeef", obs_rx); end
  endtask

  task automatic test_back_to_back();
    int loads = 0, dones = 0, load1_at = -1, load2_at = -1, done2_at = -1;
    logic [31:0] d1 = 'x, d2 = 'x;
    logic ready_fin = 1'bx;
    use_model = 1'b1;
    CMD_VALID = 1'b1; CMD_WORD = 32'h1111_1111; CMD_DIR = 1'b0; CMD_LEN = 6'd2; CMD_FILL = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge CLK);
      if (ENB && MODO == 2'b10) begin
        loads++;
        if (loads == 1) begin load1_at = i; d1 = D; end
        if (loads == 2) begin load2_at = i; d2 = D; end
      end
      if (DONE) begin
        dones++;
        if (dones == 1) ready_fin = CMD_READY;
        if (dones == 2) done2_at = i;
      end
      if (i == 1) CMD_WORD = 32'h2222_2222;
      if (loads == 2 || i == 8) CMD_VALID = 1'b0;
    end
    checks++; if (loads !== 2 || dones !== 2) begin failures++; $display("FAIL b2b_counts got=%0d/%0d want=2/2", loads, dones); end
    checks++; if (load1_at !== 1 || d1 !== 32'h1111_1111) begin failures++; $display("FAIL b2b_first got=%0d %h want=1 11111111", load1_at, d1); end
    checks++; if (load2_at !== 6 || d2 !== 32'h2222_2222) begin failures++; $display("FAIL b2b_second got=%0d %h want=6 22222222", load2_at, d2); end
    checks++; if (ready_fin !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_fin got=%b want=0", ready_fin); end
    checks++; if (done2_at !== 9) begin failures++; $display("FAIL b2b_done2_at got=%0d want=9", done2_at); end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    use_model = 1'b1;
    CMD_VALID = 1'b1; CMD_WORD = 32'hFFFF_0000; CMD_DIR = 1'b1; CMD_LEN = 6'd16; CMD_FILL = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    for (int i = 2; i <= 6; i++) @(negedge CLK);
    checks++; if (RX_WORD !== 32'h0000_000F || MODO !== 2'b00) begin failures++; $display("FAIL mid_pre_state got=%h %b want=0000000f 00", RX_WORD, MODO); end
    RESET_L = 1'b0;
    #1;
    checks++; if (CMD_READY !== 1'b1 || ENB !== 1'b0 || MODO !== 2'b11 || BUSY !== 1'b0) begin failures++; $display("FAIL mid_async_ctrl got=%b%b%b%b want=10110", CMD_READY, ENB, MODO, BUSY); end
    checks++; if (RX_WORD !== 32'h0 || D !== 32'h0 || S_IN !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL mid_async_data got=%h %h %b %b want=0 0 0 0", RX_WORD, D, S_IN, DONE); end
    @(negedge CLK);
    RESET_L = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL mid_no_done got=%0d want=0", done_seen); end
    run_cmd(32'h0F0F_3C3C, 1'b0, 6'd4, 1'b0);
    checks++; if (done_at !== 6 || n_shift !== 4) begin failures++; $display("FAIL mid_next_timing got=%0d/%0d want=6/4", done_at, n_shift); end
    checks++; if (obs_rx !== 32'hC000_0000) begin failures++; $display("FAIL mid_next_rx got=%h want=c0000000", obs_rx); end
  endtask

  initial begin
    RESET_L = 1'b0; CMD_VALID = 1'b0; CMD_WORD = '0; CMD_DIR = 1'b0;
    CMD_LEN = '0; CMD_FILL = 1'b0; use_model = 1'b0; ser_force = 1'b0;
    test_reset();
    test_single_shift();
    test_loopback();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_32_shift_ctrl.md
Name: reg_32_shift_ctrl

Overview:
- Upstream sequencer for the 32-bit structural shift register.
- Accepts a 32-bit word plus a shift command over a valid/ready handshake.
- Parallel-loads the word into the register, then drives a programmed number of serial shift cycles in the requested direction.
- Collects the bit stream returned from the register's serial output into a receive word, and signals completion with a one-cycle pulse.

Parameters:
- WIDTH, 32, register/word width in bits.
- CNT_W, 6, width of shift counter; must hold WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_L  input  1  asynchronous active-low reset.
- CMD_VALID  input  1  command/word offered.
- CMD_READY  output  1  controller can accept a command (IDLE only).
- CMD_WORD  input  WIDTH  word to parallel-load.
- CMD_DIR  input  1  shift direction for this command (1 = toward MSB, 0 = toward LSB).
- CMD_LEN  input  CNT_W  number of shift cycles; 0 means WIDTH.
- CMD_FILL  input  1  serial fill bit driven on S_IN during shifting.
- SER_RET  input  1  serial bit returned from the register (its S_OUT).
- ENB  output  1  register enable.
- MODO  output  2  register mode: 2'b10 parallel load, 2'b00 shift, 2'b11 hold.
- DIR  output  1  register direction.
- D  output  WIDTH  parallel load data.
- S_IN  output  1  serial input to register.
- BUSY  output  1  high from command acceptance through the DONE cycle.
- DONE  output  1  one-cycle pulse at end of command.
- RX_WORD  output  WIDTH  returned bits; valid when DONE=1, held until the next acceptance.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low, named RESET_L; clock is CLK.
- All outputs are registered.
- Reset values:
  - state IDLE, CMD_READY=1, ENB=0, MODO=2'b11, DIR=0, D=0, S_IN=0, BUSY=0, DONE=0, RX_WORD=0.
  - Internal counter and latched command fields = 0.
- States: IDLE, LOAD, SHIFT, FIN.
- IDLE:
  - CMD_READY=1, ENB=0, MODO=2'b11.
  - Handshake fires when CMD_VALID && CMD_READY at a CLK edge. On that edge: latch WORD, DIR, FILL; load count = (CMD_LEN==0 ? WIDTH : CMD_LEN); clear RX_WORD; CMD_READY->0, BUSY->1; go to LOAD.
  - CMD_VALID while not READY is ignored; the source must hold it.
- LOAD (exactly 1 cycle):
  - ENB=1, MODO=2'b10, D=latched word, DIR=latched dir.
  - Then go to SHIFT.
- SHIFT (exactly count cycles):
  - ENB=1, MODO=2'b00, DIR=latched dir, S_IN=latched fill.
  - Each SHIFT cycle the counter decrements, and SER_RET is sampled into RX_WORD:
    - dir=1: RX_WORD <= {RX_WORD[WIDTH-2:0], SER_RET}.
    - dir=0: RX_WORD <= {SER_RET, RX_WORD[WIDTH-1:1]}.
  - On the cycle the counter reaches 1, go to FIN.
- FIN (1 cycle):
  - ENB=0, MODO=2'b11, DONE=1, BUSY=1.
  - Next state IDLE, with CMD_READY=1 and BUSY=0.
- Throughput: 1 + N + 1 cycles per command after acceptance. Back-to-back commands are accepted on the first IDLE cycle after FIN; no command is accepted during FIN.
- CMD_LEN > WIDTH: saturate to WIDTH.
- D is held at its last value outside LOAD. S_IN=0 outside SHIFT.
- Reset asserted mid-command: immediate return to reset values, no DONE pulse, RX_WORD cleared.
- Reset deassertion is synchronised externally; the block itself takes no special action.

Test Plan:
- Reset check: hold RESET_L=0 with random inputs -> CMD_READY=1, ENB=0, MODO=2'b11, DONE=0, RX_WORD=0.
- Single shift:
  - Stimulus: CMD_WORD=32'hA5A5_0001, DIR=1, LEN=1, FILL=0, SER_RET=1.
  - Response: LOAD cycle with D=32'hA5A5_0001 and MODO=10; one SHIFT cycle with MODO=00, DIR=1; DONE at acceptance+3; RX_WORD=32'h0000_0001.
- Full 32-bit loopback:
  - Stimulus: LEN=0 (means 32), DIR=0, FILL=1, SER_RET fed by a bench model of the register.
  - Response: exactly 32 SHIFT cycles with ENB=1; DONE at acceptance+34; RX_WORD equals the loaded word.
- Handshake stall: CMD_VALID held high across a busy command -> second command accepted only on the first cycle after FIN; no command lost or duplicated.
- Saturation: LEN=6'd40 -> exactly 32 SHIFT cycles.
- Reset mid-command: pulse RESET_L low during SHIFT cycle 5 of 16 -> outputs return to reset values asynchronously; no DONE pulse; the next command behaves normally.
